debounce_edge: RTL and testbench
================================

// Module: debounce_edge
// PURPOSE
//  Consumes the two-flop-synchronised level from synchroniser (its y output).
//  Filters contact bounce by requiring N consecutive identical samples before
//  the debounced level changes. Emits single-cycle rise and fall pulses for
//  downstream control logic.
//  Sits directly after synchroniser, one instance per external input.
// PARAMETERS
//  DEBOUNCE_CYCLES  16     consecutive samples needed to accept a change; legal >= 2
//  REPEAT_CYCLES    1000   auto-repeat period in clocks; used only with DEBOUNCE_REPEAT_EN; legal >= 2
//  CNT_W            $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)+1)   counter width (derived)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  sync_in       in   1  synchronised level from synchroniser.y
//  level_out     out  1  debounced level (registered)
//  rise_pulse    out  1  1-cycle pulse when level_out goes 0->1
//  fall_pulse    out  1  1-cycle pulse when level_out goes 1->0
//  repeat_pulse  out  1  1-cycle auto-repeat pulse while held high; 0 if macro absent
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_LOW, cnt=0, level_out=0.
//    rise_pulse, fall_pulse and repeat_pulse are 0. Release of reset takes effect at the next clk edge.
//  - FSM states: S_LOW, S_PEND_HI, S_HIGH, S_PEND_LO. Transitions are evaluated each posedge clk:
//    S_LOW:     sync_in=1 -> S_PEND_HI, cnt=1; else stay, cnt=0.
//    S_PEND_HI: sync_in=0 -> S_LOW, cnt=0.
//               sync_in=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, level_out=1, rise_pulse=1, cnt=0.
//               otherwise cnt++.
//    S_HIGH / S_PEND_LO: mirror of S_LOW / S_PEND_HI with sync_in inverted.
//               The accepting edge sets level_out=0 and fall_pulse=1.
//  - Latency: level_out changes on the DEBOUNCE_CYCLES-th consecutive rising edge that samples
//    the new value. Counting starts from the first such edge.
//  - Pulses are registered, high for exactly one clock, and never overlap.
//    rise_pulse and fall_pulse are never both 1.
//  - Any single contrary sample in a PEND state aborts it. cnt restarts from 0 and level_out is unchanged.
//  - cnt never exceeds DEBOUNCE_CYCLES-1 in PEND states. No wrap-around is possible.
//  - An input toggling every cycle forever keeps level_out constant and produces no pulses.
//  - Reset asserted mid-PEND discards the pending count. No pulse is emitted.
// CONFIGURATION
//  Macro DEBOUNCE_REPEAT_EN:
//   Defined:
//    - In S_HIGH a repeat counter increments each clk.
//    - At REPEAT_CYCLES-1 it clears and repeat_pulse=1 for one cycle.
//    - The counter clears on entry to S_HIGH, so the first repeat comes REPEAT_CYCLES clocks after rise_pulse.
//    - In S_PEND_LO the repeat counter holds and no repeat pulses are emitted.
//    - Returning to S_HIGH from S_PEND_LO resumes counting from the held value.
//   Undefined: the repeat counter is not built and repeat_pulse is tied 0. The port is always present.
// STRUCTURE
//  - Package debounce_pkg: typedef enum logic [1:0] deb_state_t {S_LOW,S_PEND_HI,S_HIGH,S_PEND_LO},
//    plus function clog2_max for CNT_W.
//  - Sub-module debounce_counter (clr, inc, terminal-count compare, output tc). It is instantiated once
//    for the debounce count and once, under the macro, for the repeat count.
//  - The FSM and output registers live in debounce_edge.
// TESTING (bench: 20 ns clk, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8; drive sync_in after negedge)
//  1. Reset: hold rst_n=0 for 3 clk with sync_in=1 -> all outputs 0. After release, level_out=1 on the 4th posedge.
//  2. Glitch: sync_in high for 3 clk then low -> level_out stays 0 and rise_pulse never asserts.
//  3. Clean press and release: high 10 clk then low 10 clk -> rise_pulse for 1 clk at the 4th high edge.
//     fall_pulse for 1 clk at the 4th low edge.
//  4. Chatter: sync_in toggles every clk for 40 clk from level 0 -> no pulses and level_out=0 throughout.
//  5. Reset mid-pend: sync_in=1 for 2 clk, then async rst_n pulse between edges -> cnt cleared.
//     Re-acceptance needs 4 more high edges.
//  6. Macro defined, hold high 30 clk -> repeat_pulse at 8, 16 and 24 clk after rise_pulse.
//     Macro undefined -> repeat_pulse stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_edge slice: FSM state encoding and
// the counter-width function used to size the debounce and repeat counters.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_PEND_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_PEND_LO = 2'd3
  } deb_state_t;

  // Bits needed to hold max(a, b); elaboration-time only.
  function automatic int clog2_max(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = 0;
    while ((1 << w) < (m + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// Clearable up-counter with a terminal-count flag; clear has priority over increment.
module debounce_counter #(
  parameter int W    = 5,
  parameter int TERM = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/debounce_edge.sv
// Debounces a synchronised level and emits registered rise/fall pulses.
// Optional auto-repeat while held high is built when DEBOUNCE_REPEAT_EN is defined.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000,
  parameter int CNT_W           = clog2_max(DEBOUNCE_CYCLES, REPEAT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse
);

  deb_state_t state, state_nxt;
  logic       level_nxt, rise_nxt, fall_nxt, repeat_nxt;
  logic       deb_clr, deb_inc, deb_tc;

  debounce_counter #(.W(CNT_W), .TERM(DEBOUNCE_CYCLES - 1)) u_deb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (deb_clr),
    .inc   (deb_inc),
    .tc    (deb_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOW;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    deb_clr   = 1'b0;
    deb_inc   = 1'b0;
    unique case (state)
      S_LOW: begin
        if (sync_in) begin state_nxt = S_PEND_HI; deb_inc = 1'b1; end
        else         deb_clr = 1'b1;
      end
      S_PEND_HI: begin
        if (!sync_in) begin
          state_nxt = S_LOW;
          deb_clr   = 1'b1;
        end else if (deb_tc) begin
          state_nxt = S_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          deb_clr   = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin state_nxt = S_PEND_LO; deb_inc = 1'b1; end
        else          deb_clr = 1'b1;
      end
      S_PEND_LO: begin
        if (sync_in) begin
          state_nxt = S_HIGH;
          deb_clr   = 1'b1;
        end else if (deb_tc) begin
          state_nxt = S_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          deb_clr   = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        deb_clr   = 1'b1;
      end
    endcase
  end

`ifdef DEBOUNCE_REPEAT_EN
  logic rep_clr, rep_inc, rep_tc;

  // Counts only while settled high; holds through S_PEND_LO, restarts on a new rise.
  assign rep_inc    = (state == S_HIGH);
  assign repeat_nxt = (state == S_HIGH) && rep_tc;
  assign rep_clr    = rise_nxt || repeat_nxt;

  debounce_counter #(.W(CNT_W), .TERM(REPEAT_CYCLES - 1)) u_rep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rep_clr),
    .inc   (rep_inc),
    .tc    (rep_tc)
  );
`else
  assign repeat_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_out    <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      level_out    <= level_nxt;
      rise_pulse   <= rise_nxt;
      fall_pulse   <= fall_nxt;
      repeat_pulse <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, 20 ns clock).
// Repeat expectations follow DEBOUNCE_REPEAT_EN as defined for the build.
module tb_debounce_edge;

  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sync_in;
  logic level_out, rise_pulse, fall_pulse, repeat_pulse;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic rep;
  } obs_t;

  obs_t exp_q[$];

  // Behavioural reference: run length of samples that disagree with the level.
  logic m_level;
  int   m_run;
  int   m_rep;
  logic m_rise, m_fall, m_rep_p;

  debounce_edge #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_in      (sync_in),
    .level_out    (level_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_rep   = 0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_rep_p = 1'b0;
  endfunction

  function automatic void model_step(input logic v);
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_rep_p = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    if (m_level && m_run == 0) begin
      if (m_rep == R - 1) begin m_rep = 0; m_rep_p = 1'b1; end
      else m_rep++;
    end
`endif
    if (v != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = v;
        m_run   = 0;
        if (v) begin m_rise = 1'b1; m_rep = 0; end
        else   m_fall = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  // Drives one sample after negedge, queues the expectation, compares after posedge.
  task automatic step(input logic v, input string tag);
    obs_t e, a;
    @(negedge clk);
    sync_in = v;
    model_step(v);
    exp_q.push_back({m_level, m_rise, m_fall, m_rep_p});
    @(posedge clk);
    #1;
    a = {level_out, rise_pulse, fall_pulse, repeat_pulse};
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s {lvl,rise,fall,rep} got=%b want=%b", tag, a, e);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    sync_in = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({level_out, rise_pulse, fall_pulse, repeat_pulse} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold outputs got=%b want=0000",
                 {level_out, rise_pulse, fall_pulse, repeat_pulse});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step(1'b1, "reset_accept");
      if (i == D - 1) begin
        checks++;
        if (level_out !== 1'b0) begin
          failures++;
          $display("FAIL reset_early_level got=%b want=0", level_out);
        end
      end
    end
    checks++;
    if (level_out !== 1'b1 || rise_pulse !== 1'b1) begin
      failures++;
      $display("FAIL reset_4th_edge lvl/rise got=%b%b want=11", level_out, rise_pulse);
    end
    for (int i = 0; i < D; i++) step(1'b0, "return_low");
  endtask

  task automatic test_glitch();
    int rises = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, "glitch_hi"); rises += int'(rise_pulse); end
    for (int i = 0; i < 3; i++) begin step(1'b0, "glitch_lo"); rises += int'(rise_pulse); end
    checks++;
    if (rises != 0 || level_out !== 1'b0) begin
      failures++;
      $display("FAIL glitch rises=%0d lvl=%b want rises=0 lvl=0", rises, level_out);
    end
  endtask

  task automatic test_press_release();
    int rise_at = -1;
    int fall_at = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, "press");
      if (rise_pulse === 1'b1) begin
        checks++;
        if (rise_at != -1) begin
          failures++;
          $display("FAIL press_double_rise at=%0d first=%0d", i, rise_at);
        end
        rise_at = i;
      end
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, "release");
      if (fall_pulse === 1'b1) begin
        checks++;
        if (fall_at != -1) begin
          failures++;
          $display("FAIL release_double_fall at=%0d first=%0d", i, fall_at);
        end
        fall_at = i;
      end
    end
    checks++;
    if (rise_at != D || fall_at != D) begin
      failures++;
      $display("FAIL press_release_edges rise_at=%0d fall_at=%0d want %0d/%0d",
               rise_at, fall_at, D, D);
    end
  endtask

  task automatic test_chatter();
    int pulses = 0;
    int lvl_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(logic'(i % 2 == 0), "chatter");
      pulses += int'(rise_pulse) + int'(fall_pulse);
      if (level_out !== 1'b0) lvl_bad++;
    end
    checks++;
    if (pulses != 0 || lvl_bad != 0) begin
      failures++;
      $display("FAIL chatter pulses=%0d high_cycles=%0d want 0/0", pulses, lvl_bad);
    end
    step(1'b0, "chatter_settle");
  endtask

  task automatic test_reset_mid_pend();
    step(1'b1, "midpend_pre");
    step(1'b1, "midpend_pre");
    #4 rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if ({level_out, rise_pulse, fall_pulse, repeat_pulse} !== 4'b0000) begin
      failures++;
      $display("FAIL midpend_async_reset got=%b want=0000",
               {level_out, rise_pulse, fall_pulse, repeat_pulse});
    end
    #2 rst_n = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step(1'b1, "midpend_reaccept");
      if (i < D) begin
        checks++;
        if (level_out !== 1'b0 || rise_pulse !== 1'b0) begin
          failures++;
          $display("FAIL midpend_early edge=%0d lvl/rise got=%b%b want=00",
                   i, level_out, rise_pulse);
        end
      end
    end
    checks++;
    if (level_out !== 1'b1 || rise_pulse !== 1'b1) begin
      failures++;
      $display("FAIL midpend_accept lvl/rise got=%b%b want=11", level_out, rise_pulse);
    end
  endtask

  task automatic test_repeat();
    int rise_at = -1;
    int rep_at[$];
    int want[$];
    for (int i = 0; i < D; i++) step(1'b0, "repeat_prep");
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, "repeat_hold");
      if (rise_pulse === 1'b1) rise_at = i;
      if (repeat_pulse === 1'b1) rep_at.push_back(i);
    end
`ifdef DEBOUNCE_REPEAT_EN
    want = '{D + R, D + 2 * R, D + 3 * R};
`endif
    checks++;
    if (rise_at != D) begin
      failures++;
      $display("FAIL repeat_rise_at got=%0d want=%0d", rise_at, D);
    end
    checks++;
    if (rep_at != want) begin
      failures++;
      $display("FAIL repeat_positions got=%p want=%p", rep_at, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_chatter();
    test_reset_mid_pend();
    test_repeat();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
